sine_wave_gen: RTL and testbench



---
 rtl/sine_wave_gen_pkg.sv | 21 ++
 rtl/sine_wave_gen_if.sv | 32 +++
 rtl/sine_wave_gen_tick_div.sv | 29 ++
 rtl/sine_wave_gen.sv | 76 +++++++
 tb/tb_sine_wave_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sine_wave_gen_pkg.sv
// Shared constants and the quarter-wave sine table for sine_wave_gen.
// Optional build macro used elsewhere in this slice: SINE_FREQ_WORD_EN.
package sine_pkg;

    localparam int PHASE_W  = 10;
    localparam int DATA_W   = 10;
    localparam int SINE_MID = 512;
    localparam int SINE_AMP = 511;
    localparam int QTR      = 256;   // last table index, phase of the positive peak

    localparam real PI = 3.14159265358979323846;

    // Quarter-wave table entry k (0..QTR): round(SINE_AMP * sin(2*pi*k/1024)).
    // Only ever called with elaboration-time constants, so it folds into a ROM.
    function automatic logic [8:0] sine_q(input int k);
        real a;
        a = real'(SINE_AMP) * $sin(2.0 * PI * real'(k) / 1024.0);
        return 9'($rtoi(a + 0.5));
    endfunction

endpackage

// File: rtl/sine_wave_gen_if.sv
// Control and sample bundle of sine_wave_gen.
// With SINE_FREQ_WORD_EN defined the bundle also carries phase_step.
interface sine_wave_gen_if;
    import sine_pkg::*;

    logic                run;
`ifdef SINE_FREQ_WORD_EN
    logic [PHASE_W-1:0]  phase_step;
`endif
    logic [PHASE_W-1:0]  phase;
    logic [DATA_W-1:0]   data_sin;
    logic                tick;

    // The generator drives the samples and consumes the controls.
    modport master (
        output phase, data_sin, tick,
        input  run
`ifdef SINE_FREQ_WORD_EN
        , input phase_step
`endif
    );

    // A consumer (DAC front end, test interface) sees the opposite view.
    modport slave (
        input  phase, data_sin, tick,
        output run
`ifdef SINE_FREQ_WORD_EN
        , output phase_step
`endif
    );

endinterface

// File: rtl/sine_wave_gen_tick_div.sv
// run-gated sample-rate divider: one tick every DIV enabled clocks.
// The count holds while run is low, so pausing never loses position.
module sine_tick_div #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Terminal-count tick; dropping run on the last count suppresses it.
    assign tick = run && (cnt == LAST);

    // Counter advances only when enabled and wraps after the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sine_wave_gen.sv
// Free-running sine source: divider tick -> phase accumulator -> quarter-wave
// lookup. phase and data_sin are registered on the same edge; the lookup is
// driven by the next phase so the sample carries no extra latency.
// Build macro SINE_FREQ_WORD_EN adds a per-tick phase_step input; without it
// the phase advances by one count per tick.
module sine_wave_gen
    import sine_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    sine_wave_gen_if.master    bus
);

    logic                       tick;
    logic [PHASE_W-1:0]         step;
    logic [PHASE_W-1:0]         phase_q;
    logic [PHASE_W-1:0]         phase_nxt;
    logic [DATA_W-1:0]          data_q;
    logic [DATA_W-1:0]          data_nxt;
    logic [8:0]                 lo;
    logic [8:0]                 idx;
    logic signed [10:0]         mag;
    logic signed [10:0]         sval;
    logic [8:0]                 rom [0:QTR];

    for (genvar k = 0; k <= QTR; k++) begin : g_rom
        assign rom[k] = sine_q(k);
    end

    sine_tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .run   (bus.run),
        .tick  (tick)
    );

`ifdef SINE_FREQ_WORD_EN
    assign step = bus.phase_step;
`else
    assign step = PHASE_W'(1);
`endif

    assign phase_nxt = tick ? phase_q + step : phase_q;

    // Quadrant fold: mirror the low 9 bits about 256, negate in the lower half-wave.
    always_comb begin
        lo   = phase_nxt[8:0];
        idx  = lo;
        if (lo > 9'd256) begin
            idx = 9'(10'd512 - {1'b0, lo});
        end
        mag  = signed'({2'b00, rom[idx]});
        sval = phase_nxt[PHASE_W-1] ? -mag : mag;
        data_nxt = DATA_W'(sval + 11'sd512);
    end

    // Phase and sample registers share one edge so they always agree.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            data_q  <= DATA_W'(SINE_MID);
        end else begin
            phase_q <= phase_nxt;
            data_q  <= data_nxt;
        end
    end

    assign bus.phase    = phase_q;
    assign bus.data_sin = data_q;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_sine_wave_gen.sv
// Directed bench for sine_wave_gen (DIV = 50). Define SINE_FREQ_WORD_EN to
// also exercise the phase_step input.
module tb_sine_wave_gen;

    localparam int DIV = 50;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sine_wave_gen_if bus ();

    sine_wave_gen #(.DIV(DIV)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full-circle reference: 512 + round(511*sin(2*pi*p/1024)), ties away from zero.
    function automatic int exp_sin(input int p);
        real s;
        s = 511.0 * $sin(2.0 * 3.141592653589793 * real'(p) / 1024.0);
        if (s >= 0.0) return 512 + $rtoi(s + 0.5);
        else          return 512 - $rtoi(0.5 - s);
    endfunction

    // Step until tick is seen high (sampled after an edge); n = edges taken.
    task automatic wait_tick(output int n);
        n = 0;
        while (bus.tick !== 1'b1 && n < 2 * DIV) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) check("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int total;
        int cnt_hi;
        int bad;
        int p;
        int exp_d [4];

        exp_d = '{1023, 512, 1, 512};
        rst_n    = 1'b0;
        bus.run  = 1'b0;
`ifdef SINE_FREQ_WORD_EN
        bus.phase_step = 10'd1;
`endif
        #1000;
        check("reset_phase", bus.phase, 0);
        check("reset_data",  bus.data_sin, 512);
        check("reset_tick",  bus.tick, 0);
        rst_n = 1'b1;

        // Idle with run low for 100 us.
        cnt_hi = 0;
        bad    = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (bus.tick !== 1'b0) cnt_hi++;
            if (bus.phase !== 10'd0 || bus.data_sin !== 10'd512) bad++;
        end
        check("idle_tick_count", cnt_hi, 0);
        check("idle_output_moved", bad, 0);

        // One full period from run=1; every sample against the formula.
        bus.run = 1'b1;
        total   = 0;
        for (int i = 1; i <= 1024; i++) begin
            wait_tick(n);
            check("tick_spacing", n, DIV - 1);
            step();
            total += n + 1;
            p = i % 1024;
            check("phase_seq", bus.phase, p);
            check("data_formula", bus.data_sin, exp_sin(p));
            if (i == 1) begin
                check("first_tick_edge", total, 50);
                check("tick_low_after_advance", bus.tick, 0);
            end
            if (i == 256) begin
                check("edge_of_256", total, 12800);
                check("peak_data", bus.data_sin, 1023);
            end
            if (i == 512)  check("mid_data", bus.data_sin, 512);
            if (i == 768)  check("trough_data", bus.data_sin, 1);
            if (i == 1024) check("wrap_data", bus.data_sin, 512);
        end

        // Run 5017 edges (100 ticks, cnt left at 17), then pause 100 us.
        for (int i = 0; i < 5017; i++) step();
        check("run_100_phase", bus.phase, 100);
        bus.run = 1'b0;
        #1;
        check("pause_tick_low", bus.tick, 0);
        cnt_hi = 0;
        bad    = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (bus.tick !== 1'b0) cnt_hi++;
            if (bus.phase !== 10'd100) bad++;
        end
        check("pause_tick_count", cnt_hi, 0);
        check("pause_phase_moved", bad, 0);
        bus.run = 1'b1;
        wait_tick(n);
        check("resume_tick_edge", n + 1, DIV - 17);
        step();
        check("resume_phase", bus.phase, 101);

        // Drop run during the terminal-count cycle: tick suppressed and held.
        wait_tick(n);
        bus.run = 1'b0;
        #1;
        check("suppress_tick", bus.tick, 0);
        for (int i = 0; i < 10; i++) step();
        check("suppress_phase", bus.phase, 101);
        bus.run = 1'b1;
        #1;
        check("rearm_tick", bus.tick, 1);
        step();
        check("rearm_phase", bus.phase, 102);
        check("rearm_data", bus.data_sin, exp_sin(102));

        // Advance to phase 300, then reset asynchronously mid-cycle.
        for (int i = 0; i < 198; i++) begin
            wait_tick(n);
            step();
        end
        check("pre_reset_phase", bus.phase, 300);
        check("pre_reset_data", bus.data_sin, exp_sin(300));
        for (int i = 0; i < 7; i++) step();
        #5;
        rst_n = 1'b0;
        #1;
        check("async_reset_phase", bus.phase, 0);
        check("async_reset_data", bus.data_sin, 512);
        check("async_reset_tick", bus.tick, 0);
        #40;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        check("post_reset_first_tick", n + 1, DIV);
        step();
        check("post_reset_phase", bus.phase, 1);

`ifdef SINE_FREQ_WORD_EN
        // Quarter-period step: 512, 1023, 512, 1, 512.
        rst_n = 1'b0;
        bus.phase_step = 10'd256;
        #20;
        check("step256_initial", bus.data_sin, 512);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            step();
            check("step256_phase", bus.phase, ((i + 1) * 256) % 1024);
            check("step256_data", bus.data_sin, exp_d[i]);
        end
        bus.phase_step = 10'd0;
        wait_tick(n);
        step();
        check("step0_phase", bus.phase, 0);
        check("step0_data", bus.data_sin, 512);
`else
        check("table_unused_guard", exp_d[0], 1023);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
